// File: rtl/pc_addr_unit_pkg.sv
// ---------------------------------------------------------------------------
// pc_addr_unit_pkg
// Shared encodings for the program-counter / address-bus unit:
//   cmd_e      - command codes issued by the control unit
//   vec_sel_e  - interrupt/reset vector selector codes
//   state_e    - sequencer states (2-bit encoding)
// ---------------------------------------------------------------------------
package pc_addr_unit_pkg;

  typedef enum logic [2:0] {
    CMD_NOP     = 3'd0,
    CMD_INC     = 3'd1,
    CMD_LOAD_LO = 3'd2,
    CMD_LOAD_HI = 3'd3,
    CMD_BRANCH  = 3'd4,
    CMD_VECTOR  = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {
    VEC_NMI = 2'd0,
    VEC_RES = 2'd1,
    VEC_BRK = 2'd2,
    VEC_IRQ = 2'd3
  } vec_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BR_FIX = 2'd1,
    ST_VEC_LO = 2'd2,
    ST_VEC_HI = 2'd3
  } state_e;

endpackage

// File: rtl/pc_addr_unit_page_adder.sv
// ---------------------------------------------------------------------------
// pc_addr_unit_page_adder
// Combinational DW-bit add of an unsigned page offset and a signed
// two's-complement displacement.
//   a_i      in   DW  unsigned operand (PC low byte, or zero-extended HI)
//   off_i    in   DW  signed displacement
//   sum_o    out  DW  a_i + off_i modulo 2**DW
//   cross_o  out  1   result left the page (carry for +, borrow for -)
//   up_o     out  1   1 = displacement is non-negative
// ---------------------------------------------------------------------------
module pc_addr_unit_page_adder #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] off_i,
  output logic [DW-1:0] sum_o,
  output logic          cross_o,
  output logic          up_o
);

  logic [DW:0] fullSum;

  // An unsigned add of a negative displacement carries out exactly when the
  // result stays in the page, so for negative offsets a missing carry is
  // the borrow into the previous page.
  always_comb begin
    fullSum = {1'b0, a_i} + {1'b0, off_i};
    sum_o   = fullSum[DW-1:0];
    up_o    = ~off_i[DW-1];
    cross_o = up_o ? fullSum[DW] : ~fullSum[DW];
  end

endmodule

// File: rtl/pc_addr_unit.sv
// ---------------------------------------------------------------------------
// pc_addr_unit
// Program counter and address-bus latch for the mc6502 core, including the
// multi-cycle relative-branch fix-up and vector fetch sequences.
//   clk_i         in   1   clock, rising edge
//   rst_i         in   1   asynchronous reset, active-high
//   rdy_i         in   1   1 = advance, 0 = freeze all state
//   cmd_i         in   3   command (see cmd_e), accepted only when idle
//   vecSel_i      in   2   vector selector, sampled with CMD_VECTOR
//   db_i          in   DW  read data / signed branch offset
//   pc_o          out  AW  program counter
//   ab_o          out  AW  registered address bus
//   busy_o        out  1   a multi-cycle sequence is in progress
//   pageCross_o   out  1   registered pulse: branch crossed a page
//   done_o        out  1   registered pulse: BRANCH or VECTOR completed
// ---------------------------------------------------------------------------
module pc_addr_unit
  import pc_addr_unit_pkg::*;
#(
  parameter int             DW      = 8,
  parameter int             AW      = 16,
  parameter logic [AW-1:0]  PC_INIT = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rdy_i,
  input  logic [2:0]    cmd_i,
  input  logic [1:0]    vecSel_i,
  input  logic [DW-1:0] db_i,
  output logic [AW-1:0] pc_o,
  output logic [AW-1:0] ab_o,
  output logic          busy_o,
  output logic          pageCross_o,
  output logic          done_o
);

  // Lowest vector address (NMI) is 2**AW - 6.
  localparam logic [AW-1:0] VEC_BASE = ~AW'(5);

  logic [AW-1:0]    pc_q, pc_d;
  logic [AW-1:0]    ab_q, ab_d;
  state_e           state_q, state_d;
  logic             pageCross_q, pageCross_d;
  logic             done_q, done_d;
  logic             brUp_q, brUp_d;

  logic [DW-1:0]    lo;
  logic [AW-DW-1:0] hi;
  logic [DW-1:0]    addA, addB, addSum;
  logic             addCross, addUp;
  logic [1:0]       selEff;
  logic [AW-1:0]    vecAddr;
  logic [AW-1:0]    loadHiPc, fixPc;

  assign lo = pc_q[DW-1:0];
  assign hi = pc_q[AW-1:DW];

  // One adder serves both paths: in BR_FIX it steps the zero-extended HI
  // by +1 or -1, otherwise it adds the branch offset to LO.
  always_comb begin
    if (state_q == ST_BR_FIX) begin
      addA = DW'(hi);
      addB = brUp_q ? DW'(1) : '1;
    end else begin
      addA = lo;
      addB = db_i;
    end
  end

  pc_addr_unit_page_adder #(.DW(DW)) u_pageAdder (
    .a_i     (addA),
    .off_i   (addB),
    .sum_o   (addSum),
    .cross_o (addCross),
    .up_o    (addUp)
  );

  // Both IRQ selector codes share the BRK/IRQ vector. The truncating casts
  // keep only the HI-width part of the value placed above LO.
  always_comb begin
    selEff   = (vecSel_i == VEC_IRQ) ? VEC_BRK : vecSel_i;
    vecAddr  = VEC_BASE + AW'({selEff, 1'b0});
    loadHiPc = AW'({db_i, lo});
    fixPc    = AW'({addSum, lo});
  end

  // Next-state logic. With rdy_i low every register, pulses included,
  // keeps its value, so a wait stretches any state by the low cycles.
  always_comb begin
    pc_d        = pc_q;
    ab_d        = ab_q;
    state_d     = state_q;
    pageCross_d = pageCross_q;
    done_d      = done_q;
    brUp_d      = brUp_q;
    if (rdy_i) begin
      pageCross_d = 1'b0;
      done_d      = 1'b0;
      case (state_q)
        ST_IDLE: begin
          case (cmd_i)
            CMD_INC: begin
              pc_d = pc_q + AW'(1);
              ab_d = pc_q + AW'(1);
            end
            CMD_LOAD_LO: pc_d = {hi, db_i};
            CMD_LOAD_HI: begin
              pc_d = loadHiPc;
              ab_d = loadHiPc;
            end
            CMD_BRANCH: begin
              pc_d = {hi, addSum};
              ab_d = {hi, addSum};
              if (addCross) begin
                pageCross_d = 1'b1;
                brUp_d      = addUp;
                state_d     = ST_BR_FIX;
              end else begin
                done_d      = 1'b1;
              end
            end
            CMD_VECTOR: begin
              ab_d    = vecAddr;
              state_d = ST_VEC_LO;
            end
            default: ;
          endcase
        end
        ST_BR_FIX: begin
          pc_d    = fixPc;
          ab_d    = fixPc;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        // AB still holds the vector address here, so +1 gives its high byte.
        ST_VEC_LO: begin
          pc_d    = {hi, db_i};
          ab_d    = ab_q + AW'(1);
          state_d = ST_VEC_HI;
        end
        ST_VEC_HI: begin
          pc_d    = loadHiPc;
          ab_d    = loadHiPc;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers; reset may land at any point, including mid-sequence.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q        <= PC_INIT;
      ab_q        <= PC_INIT;
      state_q     <= ST_IDLE;
      pageCross_q <= 1'b0;
      done_q      <= 1'b0;
      brUp_q      <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ab_q        <= ab_d;
      state_q     <= state_d;
      pageCross_q <= pageCross_d;
      done_q      <= done_d;
      brUp_q      <= brUp_d;
    end
  end

  assign pc_o        = pc_q;
  assign ab_o        = ab_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign pageCross_o = pageCross_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_pc_addr_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_addr_unit
// Directed bench for pc_addr_unit: a table of single-command vectors plus
// hand-written sequences for vectors, wait states, busy-time commands,
// mid-sequence reset and a narrow AW=12 instance.
// ---------------------------------------------------------------------------
module tb_pc_addr_unit;
  import pc_addr_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [2:0]  cmd;
  logic [1:0]  vecSel;
  logic [7:0]  db;

  logic [15:0] pc, ab;
  logic        busy, pcross, done;
  logic [11:0] pc12, ab12;
  logic        busy12, pcross12, done12;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    string       name;
    logic [15:0] startPc;
    logic [2:0]  cmd;
    logic [7:0]  db;
    logic [15:0] expPc;
    logic [15:0] expAb;
    logic        expPcross;
    logic        expDone;
    logic        expBusy;
    logic        twoCycle;
    logic [15:0] fixPc;
  } vector_t;

  vector_t vecs[14];

  pc_addr_unit #(.DW(8), .AW(16), .PC_INIT(16'h0000)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rdy_i       (rdy),
    .cmd_i       (cmd),
    .vecSel_i    (vecSel),
    .db_i        (db),
    .pc_o        (pc),
    .ab_o        (ab),
    .busy_o      (busy),
    .pageCross_o (pcross),
    .done_o      (done)
  );

  pc_addr_unit #(.DW(8), .AW(12), .PC_INIT(12'h000)) dut12 (
    .clk_i       (clk),
    .rst_i       (rst),
    .rdy_i       (rdy),
    .cmd_i       (cmd),
    .vecSel_i    (vecSel),
    .db_i        (db),
    .pc_o        (pc12),
    .ab_o        (ab12),
    .busy_o      (busy12),
    .pageCross_o (pcross12),
    .done_o      (done12)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then step to just after the next rising edge.
  task automatic applyStimulus(input logic [2:0] c, input logic [7:0] d,
                               input logic r, input logic [1:0] vs);
    cmd    = c;
    db     = d;
    rdy    = r;
    vecSel = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] ePc,
                             input logic [15:0] eAb, input logic ePcross,
                             input logic eDone, input logic eBusy);
    vecCount++;
    if ({pc, ab, pcross, done, busy} !== {ePc, eAb, ePcross, eDone, eBusy}) begin
      missCount++;
      $display("[TB] FAIL %s: got pc=%h ab=%h pcross=%b done=%b busy=%b, want pc=%h ab=%h pcross=%b done=%b busy=%b",
               name, pc, ab, pcross, done, busy, ePc, eAb, ePcross, eDone, eBusy);
    end
  endtask

  task automatic checkOutput12(input string name, input logic [11:0] ePc,
                               input logic [11:0] eAb, input logic eBusy);
    vecCount++;
    if ({pc12, ab12, busy12} !== {ePc, eAb, eBusy}) begin
      missCount++;
      $display("[TB] FAIL %s: got pc=%h ab=%h busy=%b, want pc=%h ab=%h busy=%b",
               name, pc12, ab12, busy12, ePc, eAb, eBusy);
    end
  endtask

  // Preload PC with LOAD_LO then LOAD_HI, which also leaves AB = PC.
  task automatic setPc(input logic [15:0] v);
    applyStimulus(CMD_LOAD_LO, v[7:0], 1'b1, 2'd0);
    applyStimulus(CMD_LOAD_HI, v[15:8], 1'b1, 2'd0);
  endtask

  // Main test sequence: table vectors first, then multi-cycle corner cases.
  initial begin
    vecs[0]  = '{"inc_wrap",   16'hFFFF, CMD_INC,     8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{"inc",        16'h1234, CMD_INC,     8'h00, 16'h1235, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[2]  = '{"br_nocross", 16'h12F0, CMD_BRANCH,  8'h05, 16'h12F5, 16'h12F5, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{"br_cross",   16'h12F0, CMD_BRANCH,  8'h20, 16'h1210, 16'h1210, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1310};
    vecs[4]  = '{"br_neg_x",   16'h1205, CMD_BRANCH,  8'hF0, 16'h12F5, 16'h12F5, 1'b1, 1'b0, 1'b1, 1'b1, 16'h11F5};
    vecs[5]  = '{"br_neg80",   16'h1280, CMD_BRANCH,  8'h80, 16'h1200, 16'h1200, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[6]  = '{"br_7f_x",    16'h12FF, CMD_BRANCH,  8'h7F, 16'h127E, 16'h127E, 1'b1, 1'b0, 1'b1, 1'b1, 16'h137E};
    vecs[7]  = '{"br_ff_x",    16'h1200, CMD_BRANCH,  8'hFF, 16'h12FF, 16'h12FF, 1'b1, 1'b0, 1'b1, 1'b1, 16'h11FF};
    vecs[8]  = '{"br_wrap",    16'hFFF0, CMD_BRANCH,  8'h20, 16'hFF10, 16'hFF10, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0010};
    vecs[9]  = '{"load_lo",    16'h1234, CMD_LOAD_LO, 8'hAB, 16'h12AB, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[10] = '{"load_hi",    16'h1234, CMD_LOAD_HI, 8'h56, 16'h5634, 16'h5634, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[11] = '{"cmd6_nop",   16'h1234, 3'd6,        8'h77, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[12] = '{"cmd0_nop",   16'h4321, CMD_NOP,     8'h77, 16'h4321, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[13] = '{"br_zero",    16'h0000, CMD_BRANCH,  8'h00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};

    rst    = 1'b1;
    rdy    = 1'b1;
    cmd    = CMD_NOP;
    vecSel = 2'd0;
    db     = 8'h00;
    #12;
    checkOutput("reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < 14; i++) begin
      setPc(vecs[i].startPc);
      applyStimulus(vecs[i].cmd, vecs[i].db, 1'b1, 2'd0);
      checkOutput(vecs[i].name, vecs[i].expPc, vecs[i].expAb,
                  vecs[i].expPcross, vecs[i].expDone, vecs[i].expBusy);
      if (vecs[i].twoCycle) begin
        applyStimulus(CMD_NOP, 8'h00, 1'b1, 2'd0);
        checkOutput({vecs[i].name, "_fix"}, vecs[i].fixPc, vecs[i].fixPc,
                    1'b0, 1'b1, 1'b0);
      end
    end

    $display("[TB] vector fetch");
    setPc(16'h0100);
    applyStimulus(CMD_VECTOR, 8'h00, 1'b1, 2'd1);
    checkOutput("vec_addr_lo", 16'h0100, 16'hFFFC, 1'b0, 1'b0, 1'b1);
    applyStimulus(CMD_NOP, 8'h34, 1'b1, 2'd0);
    checkOutput("vec_addr_hi", 16'h0134, 16'hFFFD, 1'b0, 1'b0, 1'b1);
    applyStimulus(CMD_NOP, 8'h12, 1'b1, 2'd0);
    checkOutput("vec_done", 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0);
    applyStimulus(CMD_NOP, 8'h00, 1'b0, 2'd0);
    checkOutput("done_held", 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0);
    applyStimulus(CMD_NOP, 8'h00, 1'b1, 2'd0);
    checkOutput("done_clear", 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0);

    $display("[TB] vector fetch with wait states");
    setPc(16'h0100);
    applyStimulus(CMD_VECTOR, 8'h00, 1'b1, 2'd1);
    checkOutput("stall_accept", 16'h0100, 16'hFFFC, 1'b0, 1'b0, 1'b1);
    applyStimulus(CMD_NOP, 8'h99, 1'b0, 2'd0);
    checkOutput("stall_1", 16'h0100, 16'hFFFC, 1'b0, 1'b0, 1'b1);
    applyStimulus(CMD_NOP, 8'h99, 1'b0, 2'd0);
    checkOutput("stall_2", 16'h0100, 16'hFFFC, 1'b0, 1'b0, 1'b1);
    applyStimulus(CMD_NOP, 8'h34, 1'b1, 2'd0);
    checkOutput("stall_hi", 16'h0134, 16'hFFFD, 1'b0, 1'b0, 1'b1);
    applyStimulus(CMD_NOP, 8'h12, 1'b1, 2'd0);
    checkOutput("stall_done", 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0);

    $display("[TB] other vectors and commands while busy");
    setPc(16'h0100);
    applyStimulus(CMD_VECTOR, 8'h00, 1'b1, 2'd3);
    checkOutput("vec_irq", 16'h0100, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    applyStimulus(CMD_INC, 8'h78, 1'b1, 2'd0);
    checkOutput("inc_in_veclo", 16'h0178, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    applyStimulus(CMD_INC, 8'h56, 1'b1, 2'd0);
    checkOutput("inc_in_vechi", 16'h5678, 16'h5678, 1'b0, 1'b1, 1'b0);
    applyStimulus(CMD_VECTOR, 8'h00, 1'b1, 2'd0);
    checkOutput("vec_nmi", 16'h5678, 16'hFFFA, 1'b0, 1'b0, 1'b1);
    applyStimulus(CMD_NOP, 8'hCD, 1'b1, 2'd0);
    applyStimulus(CMD_NOP, 8'hAB, 1'b1, 2'd0);
    checkOutput("vec_nmi_done", 16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b0);
    applyStimulus(CMD_VECTOR, 8'h00, 1'b1, 2'd2);
    checkOutput("vec_brk", 16'hABCD, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    applyStimulus(CMD_NOP, 8'h00, 1'b1, 2'd0);
    applyStimulus(CMD_NOP, 8'h00, 1'b1, 2'd0);
    setPc(16'h12F0);
    applyStimulus(CMD_BRANCH, 8'h20, 1'b1, 2'd0);
    checkOutput("br_busy", 16'h1210, 16'h1210, 1'b1, 1'b0, 1'b1);
    applyStimulus(CMD_INC, 8'h00, 1'b1, 2'd0);
    checkOutput("inc_in_brfix", 16'h1310, 16'h1310, 1'b0, 1'b1, 1'b0);

    $display("[TB] reset during VEC_HI");
    setPc(16'h0100);
    applyStimulus(CMD_VECTOR, 8'h00, 1'b1, 2'd1);
    applyStimulus(CMD_NOP, 8'h34, 1'b1, 2'd0);
    checkOutput("pre_reset", 16'h0134, 16'hFFFD, 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    applyStimulus(CMD_INC, 8'h12, 1'b1, 2'd0);
    checkOutput("post_reset_inc", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);

    $display("[TB] AW=12 instance");
    setPc(16'hAFFF);
    checkOutput12("aw12_load", 12'hFFF, 12'hFFF, 1'b0);
    applyStimulus(CMD_INC, 8'h00, 1'b1, 2'd0);
    checkOutput12("aw12_wrap", 12'h000, 12'h000, 1'b0);
    checkOutput("aw16_inc", 16'hB000, 16'hB000, 1'b0, 1'b0, 1'b0);
    applyStimulus(CMD_VECTOR, 8'h00, 1'b1, 2'd1);
    checkOutput12("aw12_vec", 12'h000, 12'hFFC, 1'b1);
    applyStimulus(CMD_NOP, 8'h34, 1'b1, 2'd0);
    checkOutput12("aw12_vec_hi", 12'h034, 12'hFFD, 1'b1);
    applyStimulus(CMD_NOP, 8'h12, 1'b1, 2'd0);
    checkOutput12("aw12_vec_done", 12'h234, 12'h234, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
